ccip_mmio_csr_responder: RTL and testbench
==========================================

// Module: ccip_mmio_csr_responder
//
// PURPOSE
//  - AFU-side MMIO responder. It sits downstream of the CCI-P shim, in the AFU clock domain, and answers the FIU's MMIO requests.
//  - Decodes MMIO read/write headers on Rx channel c0 and holds a 64-bit CSR file: DFH, AFU_ID lo/hi, then RW registers.
//  - Returns read data on Tx channel c2 with the originating tid.
//  - c2 has no almost-full, so every MMIO read gets exactly one response, at fixed latency.
//
// PARAMETERS
//  - NUM_CSRS      16         64-bit CSR count, power of 2, 4..256.
//  - BASE_DW_ADDR  16'h0000   DWORD address of CSR 0; must be 2*NUM_CSRS aligned.
//  - AFU_DFH       64'h1000_0000_0000_0000   Read-only value at CSR 0.
//  - AFU_ID        128'h0     CSR 1 = AFU_ID[63:0]; CSR 2 = AFU_ID[127:64]. Both read-only.
//
// PORTS
//  - clk           in   1                       AFU clock.
//  - reset_n       in   1                       Async assert, active-low; deassert synchronous to clk upstream.
//  - cp2af_sRxC0   in   t_if_ccip_c0_Rx         Uses hdr (t_ccip_c0_ReqMmioHdr: address, length, tid), data[63:0], mmioRdValid, mmioWrValid.
//  - af2cp_sTxC2   out  t_if_ccip_c2_Tx         Read response: hdr.tid, mmioRdValid, data[63:0].
//  - csr_q         out  [NUM_CSRS][63:0]        Current CSR values.
//  - csr_wr_stb    out  [NUM_CSRS]              One-cycle pulse when CSR i is written.
//
// BEHAVIOUR
//  - Decode:
//    - idx = (address - BASE_DW_ADDR) >> 1.
//    - hit = address within [BASE, BASE + 2*NUM_CSRS).
//    - length: 0 = 4B, 1 = 8B, 2 = 64B.
//  - Write (mmioWrValid, cycle T):
//    - 4B write: address[0] = 0 writes bits [31:0]; address[0] = 1 writes [63:32].
//    - 8B write: writes [63:0]; address[0] = 1 is ignored.
//    - 64B write, miss, or write to CSR 0..2: ignored.
//    - New value is visible on csr_q at T+1; csr_wr_stb[idx] = 1 during T+1 only.
//  - Read pipeline (mmioRdValid, cycle T):
//    - S1 registers tid, idx, hit, length and address[0] at T+1.
//    - S2 muxes data and drives c2 at T+2. Latency is exactly 2 cycles.
//    - Fully pipelined: one request per cycle, no stall, no backpressure.
//  - Read data:
//    - 8B hit: returns the full CSR.
//    - 4B hit: returns the selected dword in data[31:0]; data[63:32] = 0.
//    - Miss, 64B, or 8B with address[0] = 1: data = 64'h0, and a response is still sent.
//  - Ordering: a read at T+1 following a write at T to the same CSR returns the new value. Reads and writes never share a cycle, since c0 carries a single header.
//  - Unused c2 fields: driven 0 whenever mmioRdValid = 0.
//  - Reset: async clear of all CSRs, pipeline valids, csr_wr_stb and af2cp_sTxC2 to 0.
//    - An in-flight read is dropped on reset; the FIU is reset with it.
//  - No state machine; pipeline state is valid bits only.
//
// CONFIGURATION
//  - CCIP_MMIO_RESPONDER_STATS_EN defined:
//    - CSR NUM_CSRS-2 becomes a read-only count of MMIO reads received (all reads, hit or miss).
//    - CSR NUM_CSRS-1 becomes a read-only count of MMIO writes received.
//    - Both are 64-bit, wrap at 2^64, and cleared by reset.
//    - Writes to these CSRs are ignored and csr_wr_stb stays 0.
//    - A counter increments in the cycle after the request.
//  - Not defined: both CSRs are ordinary RW.
//
// STRUCTURE
//  - Shared package ccip_mmio_csr_pkg:
//    - Length encodings (MMIO_LEN_4B/8B/64B).
//    - CSR_IDX_DFH = 0, CSR_IDX_AFU_ID_L = 1, CSR_IDX_AFU_ID_H = 2.
//    - Function csr_idx_of(address, base) returning {hit, idx}.
//  - Sub-module ccip_mmio_rd_pipe: the S1/S2 read pipeline (tid, idx, length, address[0]) with a read-data callback mux input.
//  - Top level: write decode, CSR file, counters.
//
// TESTING
//  - Reset: reset_n = 0 mid-read -> af2cp_sTxC2.mmioRdValid = 0, all csr_q = 0. First read after release answers at T+2.
//  - 8B write of 64'hDEAD_BEEF_0123_4567 to BASE+6 (CSR 3), then 8B read, tid 9'h1A5:
//    - csr_wr_stb[3] pulses once.
//    - Response at T+2 with tid 1A5, data DEAD_BEEF_0123_4567.
//  - 4B write 32'hCAFE_F00D to BASE+7 -> CSR 3 = CAFE_F00D_0123_4567. 4B read of BASE+6 -> data 64'h0000_0000_0123_4567.
//  - Back-to-back reads on 8 consecutive cycles (CSR 0..2, miss, 64B, ...):
//    - 8 responses on consecutive cycles, in order, tids matched.
//    - Miss and 64B return 0. CSR 0 returns AFU_DFH.
//  - Write at T then read of same CSR at T+1 -> new value returned. Write to CSR 1 -> ignored, no strobe.
//  - STATS_EN: 5 reads + 3 writes -> CSR NUM_CSRS-2 reads 5 (that read counts after it), CSR NUM_CSRS-1 reads 3. Writing them does not change them.

Source files
------------

// File: rtl/ccip_mmio_csr_pkg.sv
// Shared types and helpers for the CCI-P MMIO CSR responder: c0/c2 channel
// subsets, MMIO length encodings, fixed CSR indices and the address decoder.
package ccip_mmio_csr_pkg;

  typedef enum logic [1:0] {
    MMIO_LEN_4B   = 2'd0,
    MMIO_LEN_8B   = 2'd1,
    MMIO_LEN_64B  = 2'd2,
    MMIO_LEN_RSVD = 2'd3
  } t_mmio_len;

  localparam int CSR_IDX_DFH      = 0;
  localparam int CSR_IDX_AFU_ID_L = 1;
  localparam int CSR_IDX_AFU_ID_H = 2;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [63:0]         data;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  // Returns {hit, idx[15:0]}; an address below base wraps to a large offset and misses.
  function automatic logic [16:0] csr_idx_of(input logic [15:0] address,
                                             input logic [15:0] base,
                                             input int unsigned num_csrs);
    logic [15:0] offset;
    logic [16:0] span;
    offset = address - base;
    span   = 17'(2 * num_csrs);
    return {({1'b0, offset} < span), 1'b0, offset[15:1]};
  endfunction

endpackage

// File: rtl/ccip_mmio_rd_pipe.sv
// Two-stage MMIO read pipeline: S1 captures the request, S2 shapes the CSR
// word supplied by the parent for the S1 index and drives Tx c2.
module ccip_mmio_rd_pipe
  import ccip_mmio_csr_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rd_valid_i,
  input  logic [8:0]       tid_i,
  input  logic             hit_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [1:0]       len_i,
  input  logic             addr0_i,
  output logic [IDX_W-1:0] s1_idx_o,
  input  logic [63:0]      s1_csr_data_i,
  output t_if_ccip_c2_Tx   tx_o
);

  logic             s1_valid_q;
  logic [8:0]       s1_tid_q;
  logic             s1_hit_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic [1:0]       s1_len_q;
  logic             s1_addr0_q;
  logic [63:0]      rsp_data_d;
  t_if_ccip_c2_Tx   tx_d;
  t_if_ccip_c2_Tx   tx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_tid_q   <= '0;
      s1_hit_q   <= 1'b0;
      s1_idx_q   <= '0;
      s1_len_q   <= '0;
      s1_addr0_q <= 1'b0;
      tx_q       <= '0;
    end else begin
      s1_valid_q <= rd_valid_i;
      s1_tid_q   <= tid_i;
      s1_hit_q   <= hit_i;
      s1_idx_q   <= idx_i;
      s1_len_q   <= len_i;
      s1_addr0_q <= addr0_i;
      tx_q       <= tx_d;
    end
  end

  // Misses, 64B reads and misaligned 8B reads still answer, with zero data.
  always_comb begin
    rsp_data_d = '0;
    if (s1_hit_q) begin
      if (s1_len_q == MMIO_LEN_8B && !s1_addr0_q)
        rsp_data_d = s1_csr_data_i;
      else if (s1_len_q == MMIO_LEN_4B)
        rsp_data_d = {32'h0, (s1_addr0_q ? s1_csr_data_i[63:32] : s1_csr_data_i[31:0])};
    end
  end

  always_comb begin
    tx_d = '0;
    if (s1_valid_q) begin
      tx_d.mmioRdValid = 1'b1;
      tx_d.hdr.tid     = s1_tid_q;
      tx_d.data        = rsp_data_d;
    end
  end

  assign s1_idx_o = s1_idx_q;
  assign tx_o     = tx_q;

endmodule

// File: rtl/ccip_mmio_csr_responder.sv
// AFU-side MMIO responder: write decode, 64-bit CSR file and read pipeline.
// Define CCIP_MMIO_RESPONDER_STATS_EN to turn the top two CSRs into read/write counters.
module ccip_mmio_csr_responder
  import ccip_mmio_csr_pkg::*;
#(
  parameter int            NUM_CSRS     = 16,
  parameter logic [15:0]   BASE_DW_ADDR = 16'h0000,
  parameter logic [63:0]   AFU_DFH      = 64'h1000_0000_0000_0000,
  parameter logic [127:0]  AFU_ID       = 128'h0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  t_if_ccip_c0_Rx               cp2af_sRxC0,
  output t_if_ccip_c2_Tx               af2cp_sTxC2,
  output logic [NUM_CSRS-1:0][63:0]    csr_q,
  output logic [NUM_CSRS-1:0]          csr_wr_stb
);

  localparam int IDX_W = $clog2(NUM_CSRS);

  logic [16:0]                 dec;
  logic                        hit;
  logic [IDX_W-1:0]            idx;
  logic                        wr_en;
  logic [NUM_CSRS-1:0][63:0]   csr_mem_q;
  logic [NUM_CSRS-1:0][63:0]   csr_view;
  logic [NUM_CSRS-1:0]         csr_wr_stb_q;
  logic [IDX_W-1:0]            s1_idx;
  logic [63:0]                 s1_csr_data;

  assign dec = csr_idx_of(cp2af_sRxC0.hdr.address, BASE_DW_ADDR, NUM_CSRS);
  assign idx = dec[IDX_W-1:0];
  // A hit always has a zero upper index; folding that in keeps the whole decode live.
  assign hit = dec[16] && (dec[15:IDX_W] == '0);

  always_comb begin
    wr_en = cp2af_sRxC0.mmioWrValid && hit && (idx > IDX_W'(CSR_IDX_AFU_ID_H)) &&
            ((cp2af_sRxC0.hdr.length == MMIO_LEN_4B) ||
             (cp2af_sRxC0.hdr.length == MMIO_LEN_8B && !cp2af_sRxC0.hdr.address[0]));
`ifdef CCIP_MMIO_RESPONDER_STATS_EN
    if (idx >= IDX_W'(NUM_CSRS - 2))
      wr_en = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr_mem_q    <= '0;
      csr_wr_stb_q <= '0;
    end else begin
      csr_wr_stb_q <= '0;
      if (wr_en) begin
        csr_wr_stb_q[idx] <= 1'b1;
        if (cp2af_sRxC0.hdr.length == MMIO_LEN_4B) begin
          if (cp2af_sRxC0.hdr.address[0])
            csr_mem_q[idx][63:32] <= cp2af_sRxC0.data[31:0];
          else
            csr_mem_q[idx][31:0]  <= cp2af_sRxC0.data[31:0];
        end else begin
          csr_mem_q[idx] <= cp2af_sRxC0.data;
        end
      end
    end
  end

`ifdef CCIP_MMIO_RESPONDER_STATS_EN
  logic        rd_seen_q;
  logic        wr_seen_q;
  logic [63:0] rd_cnt_q;
  logic [63:0] wr_cnt_q;

  // Counting one cycle late means a read of the read counter excludes itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_seen_q <= 1'b0;
      wr_seen_q <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      rd_seen_q <= cp2af_sRxC0.mmioRdValid;
      wr_seen_q <= cp2af_sRxC0.mmioWrValid;
      if (rd_seen_q) rd_cnt_q <= rd_cnt_q + 64'd1;
      if (wr_seen_q) wr_cnt_q <= wr_cnt_q + 64'd1;
    end
  end

  always_comb begin
    csr_view               = csr_mem_q;
    csr_view[NUM_CSRS-2]   = rd_cnt_q;
    csr_view[NUM_CSRS-1]   = wr_cnt_q;
  end
`else
  always_comb begin
    csr_view = csr_mem_q;
  end
`endif

  always_comb begin
    if (s1_idx == IDX_W'(CSR_IDX_DFH))
      s1_csr_data = AFU_DFH;
    else if (s1_idx == IDX_W'(CSR_IDX_AFU_ID_L))
      s1_csr_data = AFU_ID[63:0];
    else if (s1_idx == IDX_W'(CSR_IDX_AFU_ID_H))
      s1_csr_data = AFU_ID[127:64];
    else
      s1_csr_data = csr_view[s1_idx];
  end

  ccip_mmio_rd_pipe #(
    .IDX_W (IDX_W)
  ) u_rd_pipe (
    .clk           (clk),
    .reset_n       (reset_n),
    .rd_valid_i    (cp2af_sRxC0.mmioRdValid),
    .tid_i         (cp2af_sRxC0.hdr.tid),
    .hit_i         (hit),
    .idx_i         (idx),
    .len_i         (cp2af_sRxC0.hdr.length),
    .addr0_i       (cp2af_sRxC0.hdr.address[0]),
    .s1_idx_o      (s1_idx),
    .s1_csr_data_i (s1_csr_data),
    .tx_o          (af2cp_sTxC2)
  );

  assign csr_q      = csr_view;
  assign csr_wr_stb = csr_wr_stb_q;

endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// Scoreboard bench for ccip_mmio_csr_responder: reads push expected responses,
// a negedge monitor pops and compares tid, data and arrival cycle.
module tb_ccip_mmio_csr_responder;
  import ccip_mmio_csr_pkg::*;

  localparam int            N      = 16;
  localparam logic [15:0]   BASE   = 16'h0040;
  localparam logic [63:0]   DFH    = 64'h1000_0000_0000_0000;
  localparam logic [127:0]  ID     = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
  localparam logic [63:0]   ID_LO  = 64'h0F1E_2D3C_4B5A_6978;
  localparam logic [63:0]   ID_HI  = 64'hFEDC_BA98_7654_3210;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  t_if_ccip_c0_Rx       rx;
  t_if_ccip_c2_Tx       tx;
  logic [N-1:0][63:0]   csr_q;
  logic [N-1:0]         csr_wr_stb;

  ccip_mmio_csr_responder #(
    .NUM_CSRS     (N),
    .BASE_DW_ADDR (BASE),
    .AFU_DFH      (DFH),
    .AFU_ID       (ID)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cp2af_sRxC0 (rx),
    .af2cp_sTxC2 (tx),
    .csr_q       (csr_q),
    .csr_wr_stb  (csr_wr_stb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      n_chk++;
      if (tx.mmioRdValid) begin
        if (sb.size() == 0) begin
          $display("FAIL unexpected_rsp: got tid %h data %h at cycle %0d, none expected",
                   tx.hdr.tid, tx.data, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (tx.hdr.tid === e.tid && tx.data === e.data && cyc == e.at) n_pass++;
          else $display("FAIL %s: got tid %h data %h cycle %0d expected tid %h data %h cycle %0d",
                        e.name, tx.hdr.tid, tx.data, cyc, e.tid, e.data, e.at);
        end
      end else if (tx.hdr.tid === 9'h0 && tx.data === 64'h0) begin
        n_pass++;
      end else begin
        $display("FAIL c2_idle_zero: got tid %h data %h expected 0", tx.hdr.tid, tx.data);
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    rx = '0;
  endtask

  task automatic do_wr(input logic [15:0] addr, input logic [1:0] len, input logic [63:0] data);
    @(posedge clk); #1;
    rx = '0;
    rx.hdr.address = addr;
    rx.hdr.length  = len;
    rx.data        = data;
    rx.mmioWrValid = 1'b1;
  endtask

  task automatic do_rd(input string name, input logic [15:0] addr, input logic [1:0] len,
                       input logic [8:0] tid, input logic [63:0] exp, input bit want);
    exp_t e;
    @(posedge clk); #1;
    rx = '0;
    rx.hdr.address = addr;
    rx.hdr.length  = len;
    rx.hdr.tid     = tid;
    rx.mmioRdValid = 1'b1;
    if (want) begin
      e.tid  = tid;
      e.data = exp;
      e.at   = cyc + 2;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else begin
      $display("FAIL drain_timeout: got %0d responses outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rx = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_csr_q", {63'h0, |csr_q}, 64'h0);
    check("rst_c2_valid", {63'h0, tx.mmioRdValid}, 64'h0);

    // Reset with a read in flight: response dropped, CSRs cleared.
    do_wr(BASE + 16'h000A, MMIO_LEN_8B, 64'h5555_6666_7777_8888);
    idle();
    @(negedge clk);
    check("pre_rst_csr5", csr_q[5], 64'h5555_6666_7777_8888);
    do_rd("dropped", BASE + 16'h000A, MMIO_LEN_8B, 9'h033, 64'h0, 1'b0);
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    check("midrd_rst_valid", {63'h0, tx.mmioRdValid}, 64'h0);
    check("midrd_rst_csr_q", {63'h0, |csr_q}, 64'h0);
    @(negedge clk);
    check("midrd_rst_valid2", {63'h0, tx.mmioRdValid}, 64'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    do_rd("first_rd_after_rst", BASE, MMIO_LEN_8B, 9'h001, DFH, 1'b1);
    idle();
    drain();

    // 8B write/read of CSR 3.
    do_wr(BASE + 16'h0006, MMIO_LEN_8B, 64'hDEAD_BEEF_0123_4567);
    idle();
    @(negedge clk);
    check("wr8_csr3", csr_q[3], 64'hDEAD_BEEF_0123_4567);
    check("wr8_stb", {48'h0, csr_wr_stb}, 64'h0008);
    idle();
    @(negedge clk);
    check("wr8_stb_once", {48'h0, csr_wr_stb}, 64'h0);
    do_rd("rd8_csr3", BASE + 16'h0006, MMIO_LEN_8B, 9'h1A5, 64'hDEAD_BEEF_0123_4567, 1'b1);
    idle();

    // 4B write to the upper dword, 4B reads of each half.
    do_wr(BASE + 16'h0007, MMIO_LEN_4B, 64'h0000_0000_CAFE_F00D);
    idle();
    @(negedge clk);
    check("wr4_csr3", csr_q[3], 64'hCAFE_F00D_0123_4567);
    check("wr4_stb", {48'h0, csr_wr_stb}, 64'h0008);
    do_rd("rd4_lo", BASE + 16'h0006, MMIO_LEN_4B, 9'h0A1, 64'h0000_0000_0123_4567, 1'b1);
    do_rd("rd4_hi", BASE + 16'h0007, MMIO_LEN_4B, 9'h0A2, 64'h0000_0000_CAFE_F00D, 1'b1);
    idle();
    drain();

    // Eight back-to-back reads.
    do_rd("b2b_dfh",      BASE,            MMIO_LEN_8B,  9'h100, DFH,   1'b1);
    do_rd("b2b_id_lo",    BASE + 16'h0002, MMIO_LEN_8B,  9'h101, ID_LO, 1'b1);
    do_rd("b2b_id_hi",    BASE + 16'h0004, MMIO_LEN_8B,  9'h102, ID_HI, 1'b1);
    do_rd("b2b_miss_hi",  BASE + 16'h0020, MMIO_LEN_8B,  9'h103, 64'h0, 1'b1);
    do_rd("b2b_64b",      BASE + 16'h0006, MMIO_LEN_64B, 9'h104, 64'h0, 1'b1);
    do_rd("b2b_misalign", BASE + 16'h0007, MMIO_LEN_8B,  9'h105, 64'h0, 1'b1);
    do_rd("b2b_miss_lo",  16'h0010,        MMIO_LEN_8B,  9'h106, 64'h0, 1'b1);
    do_rd("b2b_id_lo_4b", BASE + 16'h0003, MMIO_LEN_4B,  9'h107, 64'h0000_0000_0F1E_2D3C, 1'b1);
    idle();
    drain();

    // Write then immediate read of the same CSR.
    do_wr(BASE + 16'h000A, MMIO_LEN_8B, 64'h1122_3344_5566_7788);
    do_rd("wr_then_rd8", BASE + 16'h000A, MMIO_LEN_8B, 9'h055, 64'h1122_3344_5566_7788, 1'b1);
    do_wr(BASE + 16'h000A, MMIO_LEN_4B, 64'h0000_0000_9999_AAAA);
    do_rd("wr4_then_rd8", BASE + 16'h000A, MMIO_LEN_8B, 9'h057, 64'h1122_3344_9999_AAAA, 1'b1);
    idle();

    // Read-only and unsupported writes are dropped without a strobe.
    do_wr(BASE + 16'h0002, MMIO_LEN_8B, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    @(negedge clk);
    check("ro_wr_stb", {48'h0, csr_wr_stb}, 64'h0);
    check("ro_wr_csr1", csr_q[1], 64'h0);
    do_rd("ro_rd_id_lo", BASE + 16'h0002, MMIO_LEN_8B, 9'h056, ID_LO, 1'b1);
    do_wr(BASE + 16'h000C, MMIO_LEN_64B, 64'h1234_1234_1234_1234);
    idle();
    @(negedge clk);
    check("wr64_stb", {48'h0, csr_wr_stb}, 64'h0);
    check("wr64_csr6", csr_q[6], 64'h0);
    drain();

`ifndef CCIP_MMIO_RESPONDER_STATS_EN
    // Top CSR is ordinary RW in the default build.
    do_wr(BASE + 16'h001E, MMIO_LEN_8B, 64'hA5A5_5A5A_0F0F_F0F0);
    idle();
    @(negedge clk);
    check("csr15_stb", {48'h0, csr_wr_stb}, 64'h8000);
    do_rd("csr15_rd", BASE + 16'h001E, MMIO_LEN_8B, 9'h0F0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
    idle();
    drain();
`else
    // Counters from a fresh reset: 5 reads, 3 writes.
    pulse_reset();
    for (int i = 0; i < 5; i++)
      do_rd("stats_rd", BASE + 16'h0006, MMIO_LEN_8B, 9'(9'h020 + i), 64'h0, 1'b1);
    for (int i = 1; i <= 3; i++)
      do_wr(BASE + 16'h0008, MMIO_LEN_8B, 64'(i));
    do_rd("stats_rd_cnt", BASE + 16'h001C, MMIO_LEN_8B, 9'h030, 64'd5, 1'b1);
    do_rd("stats_wr_cnt", BASE + 16'h001E, MMIO_LEN_8B, 9'h031, 64'd3, 1'b1);
    do_wr(BASE + 16'h001C, MMIO_LEN_8B, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    @(negedge clk);
    check("stats_wr14_stb", {48'h0, csr_wr_stb}, 64'h0);
    do_wr(BASE + 16'h001E, MMIO_LEN_8B, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    @(negedge clk);
    check("stats_wr15_stb", {48'h0, csr_wr_stb}, 64'h0);
    do_rd("stats_rd_cnt2", BASE + 16'h001C, MMIO_LEN_8B, 9'h032, 64'd7, 1'b1);
    do_rd("stats_wr_cnt2", BASE + 16'h001E, MMIO_LEN_8B, 9'h033, 64'd5, 1'b1);
    idle();
    drain();
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
